// File: rtl/u_d_count_decoder.sv
// Protocol decoder for an up/down loadable counter: classifies each new count sample
// as step up/down, hold or parallel load, and tracks wraps, direction changes and run length.
module u_d_count_decoder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] count_in,
    output logic [1:0]       state,
    output logic             step_up,
    output logic             step_dn,
    output logic             hold,
    output logic             load_det,
    output logic [WIDTH-1:0] load_val,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             dir_chg,
    output logic [RUN_W-1:0] run_len
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DN   = 2'b10
    } dir_t;

    localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;

    state_t           state_q, state_d;
    dir_t             last_dir_q, last_dir_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             hold_q, hold_d;
    logic             load_det_q, load_det_d;
    logic             wrap_up_q, wrap_up_d;
    logic             wrap_dn_q, wrap_dn_d;
    logic             dir_chg_q, dir_chg_d;
    logic [WIDTH-1:0] delta;

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        prev_d     = prev_q;
        load_val_d = load_val_q;
        run_len_d  = run_len_q;
        step_up_d  = 1'b0;
        step_dn_d  = 1'b0;
        hold_d     = 1'b0;
        load_det_d = 1'b0;
        wrap_up_d  = 1'b0;
        wrap_dn_d  = 1'b0;
        dir_chg_d  = 1'b0;
        delta      = count_in - prev_q;

        if (valid) begin
            prev_d = count_in;
            if (state_q == ST_IDLE) begin
                // First sample after reset only seeds the reference value.
                state_d    = ST_HOLD;
                run_len_d  = '0;
                last_dir_d = DIR_NONE;
            end else if (delta == DELTA_UP) begin
                step_up_d = 1'b1;
                state_d   = ST_UP;
                wrap_up_d = (prev_q == '1);
                if (last_dir_q == DIR_UP) begin
                    run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_ONE;
                end else begin
                    run_len_d = RUN_ONE;
                    dir_chg_d = (last_dir_q == DIR_DN);
                end
                last_dir_d = DIR_UP;
            end else if (delta == '1) begin
                step_dn_d = 1'b1;
                state_d   = ST_DOWN;
                wrap_dn_d = (prev_q == '0);
                if (last_dir_q == DIR_DN) begin
                    run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_ONE;
                end else begin
                    run_len_d = RUN_ONE;
                    dir_chg_d = (last_dir_q == DIR_UP);
                end
                last_dir_d = DIR_DN;
            end else if (delta == '0) begin
                // Hold keeps the run going: direction memory survives idle counts.
                hold_d  = 1'b1;
                state_d = ST_HOLD;
            end else begin
                load_det_d = 1'b1;
                load_val_d = count_in;
                state_d    = ST_HOLD;
                run_len_d  = '0;
                last_dir_d = DIR_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            last_dir_q <= DIR_NONE;
            prev_q     <= '0;
            load_val_q <= '0;
            run_len_q  <= '0;
            step_up_q  <= 1'b0;
            step_dn_q  <= 1'b0;
            hold_q     <= 1'b0;
            load_det_q <= 1'b0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            dir_chg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            prev_q     <= prev_d;
            load_val_q <= load_val_d;
            run_len_q  <= run_len_d;
            step_up_q  <= step_up_d;
            step_dn_q  <= step_dn_d;
            hold_q     <= hold_d;
            load_det_q <= load_det_d;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            dir_chg_q  <= dir_chg_d;
        end
    end

    always_comb begin
        state    = state_q;
        step_up  = step_up_q;
        step_dn  = step_dn_q;
        hold     = hold_q;
        load_det = load_det_q;
        load_val = load_val_q;
        wrap_up  = wrap_up_q;
        wrap_dn  = wrap_dn_q;
        dir_chg  = dir_chg_q;
        run_len  = run_len_q;
    end

endmodule

// File: tb/tb_u_d_count_decoder.sv
// Scoreboard bench for u_d_count_decoder: directed scenarios plus randomized counter traffic
// checked against an arithmetic reference model.
module tb_u_d_count_decoder;

    localparam int WIDTH = 8;
    localparam int RUN_W = 4;
    localparam int M     = 1 << WIDTH;
    localparam int RMAX  = (1 << RUN_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] count_in = '0;
    logic [1:0]       state;
    logic             step_up, step_dn, hold, load_det, wrap_up, wrap_dn, dir_chg;
    logic [WIDTH-1:0] load_val;
    logic [RUN_W-1:0] run_len;

    u_d_count_decoder #(.WIDTH(WIDTH), .RUN_W(RUN_W)) dut (
        .clk(clk), .rst(rst), .valid(valid), .count_in(count_in),
        .state(state), .step_up(step_up), .step_dn(step_dn), .hold(hold),
        .load_det(load_det), .load_val(load_val), .wrap_up(wrap_up),
        .wrap_dn(wrap_dn), .dir_chg(dir_chg), .run_len(run_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, su, sd, hd, ld, lv, wu, wd, dc, rl;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    bit m_idle = 1'b1;
    int m_prev = 0;
    int m_run = 0;
    int m_dir = 0;      // 0 none, +1 up, -1 down
    int m_lv = 0;
    int m_state = 0;    // 0 idle, 1 up, 2 down, 3 hold

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit v, input int c_raw);
        exp_t e;
        int   c, d;
        c = ((c_raw % M) + M) % M;
        @(negedge clk);
        rst = r;
        valid = v;
        count_in = c[WIDTH-1:0];
        e = '{default: 0};
        if (!r) begin
            m_idle = 1'b1; m_prev = 0; m_run = 0; m_dir = 0; m_lv = 0; m_state = 0;
        end else if (v) begin
            if (m_idle) begin
                m_idle = 1'b0; m_state = 3; m_run = 0; m_dir = 0;
            end else begin
                d = (c - m_prev + M) % M;
                if (d == 1) begin
                    e.su = 1; m_state = 1;
                    e.wu = (m_prev == M - 1) ? 1 : 0;
                    if (m_dir == 1) m_run = (m_run < RMAX) ? m_run + 1 : RMAX;
                    else begin e.dc = (m_dir == -1) ? 1 : 0; m_run = 1; end
                    m_dir = 1;
                end else if (d == M - 1) begin
                    e.sd = 1; m_state = 2;
                    e.wd = (m_prev == 0) ? 1 : 0;
                    if (m_dir == -1) m_run = (m_run < RMAX) ? m_run + 1 : RMAX;
                    else begin e.dc = (m_dir == 1) ? 1 : 0; m_run = 1; end
                    m_dir = -1;
                end else if (d == 0) begin
                    e.hd = 1; m_state = 3;
                end else begin
                    e.ld = 1; m_lv = c; m_state = 3; m_run = 0; m_dir = 0;
                end
            end
            m_prev = c;
        end
        e.st = m_state; e.lv = m_lv; e.rl = m_run;
        q.push_back(e);
    endtask

    task automatic sample(input int c);
        drive(1'b1, 1'b1, c);
    endtask

    // Monitor: outputs for the inputs driven before edge N are valid just after edge N.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",    int'(state),    e.st);
                chk("step_up",  int'(step_up),  e.su);
                chk("step_dn",  int'(step_dn),  e.sd);
                chk("hold",     int'(hold),     e.hd);
                chk("load_det", int'(load_det), e.ld);
                chk("load_val", int'(load_val), e.lv);
                chk("wrap_up",  int'(wrap_up),  e.wu);
                chk("wrap_dn",  int'(wrap_dn),  e.wd);
                chk("dir_chg",  int'(dir_chg),  e.dc);
                chk("run_len",  int'(run_len),  e.rl);
            end
        end
    end

    initial begin
        int c, k, budget;
        bit r, v;

        // Reset, then load detection
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 77);
        drive(1'b1, 1'b0, 0);
        sample(0);
        sample(10);

        // Up run, reversal with hold, wrap corners
        for (int i = 10; i <= 17; i++) sample(i);
        sample(16); sample(15); sample(15); sample(14);
        sample(254); sample(255); sample(0); sample(255);
        sample(0); sample(0);

        // Saturation of the run counter
        for (int i = 0; i < RMAX + 5; i++) sample(100 + i);

        // Gaps and reset in the middle of an up run
        sample(50);
        sample(51); drive(1'b1, 1'b0, 99); sample(52); drive(1'b1, 1'b0, 3);
        drive(1'b1, 1'b0, 3); sample(53);
        drive(1'b0, 1'b1, 54);
        drive(1'b1, 1'b0, 0);
        sample(54); sample(55); sample(56);

        // Randomized counter traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 149) != 0);
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 9);
            if (k <= 3)      c = m_prev + 1;
            else if (k <= 6) c = m_prev - 1;
            else if (k == 7) c = m_prev;
            else if (k == 8) c = int'($urandom_range(0, M - 1));
            else             c = ($urandom_range(0, 1) != 0) ? M - 1 : 0;
            drive(r, v, c);
        end
        drive(1'b1, 1'b0, 0);

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #3;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
